matrix_reg_arbiter: RTL and testbench
=====================================

Name: matrix_reg_arbiter

Overview:
Round-robin arbiter sharing a bank of 256-bit matrix registers (4x4 x 16-bit elements) between several requesters, e.g. operand loader, matrix ALU and store unit. Each bank entry is a register with enable/readwrite/clk control. The block serialises accesses, drives the bank's per-register enable, shared readwrite and shared write data, captures read data, and returns a one-cycle done pulse to the granted requester.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
NUM_REGS, 8, number of 256-bit bank registers (power of 2, >=2)
AW, 3, register address width, log2(NUM_REGS)
DW, 256, data width per register

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester access request, held high until its done pulse
req_rw  input  NUM_REQ  per-requester op: 1 = read, 0 = write
req_addr  input  NUM_REQ*AW  per-requester register index, packed, requester 0 in LSBs
req_wdata  input  NUM_REQ*DW  per-requester write data, packed, requester 0 in LSBs
done  output  NUM_REQ  one-hot, one-cycle pulse: granted access completed
rdata  output  DW  read data, valid in the cycle done is high for a read
busy  output  1  high while a transaction is in ISSUE or CAPTURE
reg_enable  output  NUM_REGS  one-hot enable to the addressed bank register
reg_readwrite  output  1  to bank: 1 = read, 0 = write
reg_in  output  DW  write data to bank
reg_out  input  NUM_REGS*DW  bank register outputs, packed, register 0 in LSBs

Behaviour:
- Reset: state=IDLE, rr pointer=0, done=0, rdata=0, busy=0, reg_enable=0, reg_readwrite=1, reg_in=0.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE: if any req, select the winner by round robin starting at the rr pointer: first set req bit at index ptr, ptr+1, ... mod NUM_REQ. Latch winner index, rw, addr and wdata. Go to ISSUE. If no req, stay in IDLE.
- ISSUE (1 cycle): reg_enable = onehot(addr), reg_readwrite = rw, reg_in = wdata (wdata driven for reads too, ignored by bank). busy=1. Go to CAPTURE.
- CAPTURE (1 cycle): reg_enable=0. For a read, rdata <= reg_out slice[addr]. For a write, rdata holds its previous value. done[winner] pulses for exactly this cycle. rr pointer <= (winner+1) mod NUM_REQ. Go to IDLE.
- Throughput: one access every 3 cycles. Latency from req sampled in IDLE to done is 2 cycles.
- Requests are sampled only in IDLE. Operand changes on a granted requester after the grant are ignored. Requests arriving during ISSUE/CAPTURE wait.
- A requester deasserting req before done: the access still completes and done still pulses.
- The requester whose done is pulsing must drop req or present a new op. A req still high in the next IDLE is treated as a new access. Because of the rr update, it has the lowest priority in that arbitration.
- Simultaneous requests: exactly one grant, strictly round robin. There is no starvation; worst-case wait is NUM_REQ-1 transactions.
- Read-after-write to the same register by different requesters is ordered by grant order. A read granted after a write returns the written data.
- Address is always in range (AW matches NUM_REGS). No error path.
- Reset asserted in any state: next edge forces the reset values. An in-flight access is abandoned with no done pulse, and reg_enable drops the same edge.
- reg_enable is never multi-hot and is only nonzero in ISSUE.

Decomposition:
- Shared package matrix_pkg: DW=256, ELEM_W=16, MAT_DIM=4, state encoding constants ST_IDLE/ST_ISSUE/ST_CAPTURE, RW_READ=1/RW_WRITE=0.
- Sub-module rr_arbiter: combinational round-robin picker with inputs req and ptr, outputs grant_valid and grant_idx. It is reusable by other matrix-engine controllers.

Test Plan:
- Single write then read: req0 writes 256'h1111 to reg 2 → reg_enable=8'b00000100, reg_readwrite=0 in ISSUE, done[0] at +2 cycles. Then req0 reads reg 2 → rdata=256'h1111 with done[0].
- All three requesters request simultaneously from reset → grant order 0,1,2, done pulses at cycles 2, 5, 8. Then with req still held, order continues 0,1,2.
- Priority rotation: req1 alone, then req0 and req1 together → req0 is served before req1 (rr pointer = 2 wraps to 0).
- Ordering: req0 writes reg 5 = all-ones, req1 reads reg 5 in the same cycle → req1 rdata = all-ones.
- Mid-operation reset: assert reset during ISSUE → next cycle reg_enable=0, busy=0, no done pulse, state IDLE, rr pointer=0.
- Early drop: req2 deasserts in ISSUE → done[2] still pulses in CAPTURE, and no second access is issued.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants for the matrix-engine register bank controllers:
// matrix geometry, arbiter FSM encoding and bank read/write polarity.
package matrix_pkg;

    localparam int DW      = 256;
    localparam int ELEM_W  = 16;
    localparam int MAT_DIM = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/matrix_reg_arbiter_rr_arbiter.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic               grant_valid,
    output logic [PW-1:0]      grant_idx
);

    int cand;

    // Walk from the farthest offset down so the nearest set request wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/matrix_reg_arbiter.sv
// Round-robin access controller for a bank of 256-bit matrix registers:
// one access per three cycles (IDLE -> ISSUE -> CAPTURE), done pulse per grant.
module matrix_reg_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int NUM_REGS = 8,
    parameter int AW       = 3,
    parameter int DW       = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [NUM_REQ*AW-1:0]  req_addr,
    input  logic [NUM_REQ*DW-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     done,
    output logic [DW-1:0]          rdata,
    output logic                   busy,
    output logic [NUM_REGS-1:0]    reg_enable,
    output logic                   reg_readwrite,
    output logic [DW-1:0]          reg_in,
    input  logic [NUM_REGS*DW-1:0] reg_out
);
    import matrix_pkg::*;

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]    state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win_q;
    logic          rw_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          grant_valid;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] ptr_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_arbiter (
        .req         (req),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign ptr_next = (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            win_q   <= '0;
            rw_q    <= RW_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            done    <= '0;
            rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        win_q   <= grant_idx;
                        rw_q    <= req_rw[grant_idx];
                        addr_q  <= req_addr[grant_idx*AW +: AW];
                        wdata_q <= req_wdata[grant_idx*DW +: DW];
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Registered on entry to CAPTURE so rdata and done are
                    // visible together for the whole CAPTURE cycle.
                    if (rw_q == RW_READ) begin
                        rdata <= reg_out[addr_q*DW +: DW];
                    end
                    done  <= NUM_REQ'(1) << win_q;
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    done  <= '0;
                    ptr   <= ptr_next;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy          = (state != ST_IDLE);
        reg_enable    = '0;
        reg_readwrite = RW_READ;
        reg_in        = wdata_q;
        if (state == ST_ISSUE) begin
            reg_enable    = NUM_REGS'(1) << addr_q;
            reg_readwrite = (rw_q == RW_READ) ? RW_READ : RW_WRITE;
        end
    end

endmodule

// File: tb/tb_matrix_reg_arbiter.sv
// Directed bench for matrix_reg_arbiter with a behavioural register bank;
// expected done/rdata responses are queued at issue and checked by a monitor.
module tb_matrix_reg_arbiter;
    import matrix_pkg::*;

    localparam int NUM_REQ  = 3;
    localparam int NUM_REGS = 8;
    localparam int AW       = 3;
    localparam int EW       = 3 + 1 + DW;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NUM_REQ-1:0]     req = '0;
    logic [NUM_REQ-1:0]     req_rw = '0;
    logic [NUM_REQ*AW-1:0]  req_addr = '0;
    logic [NUM_REQ*DW-1:0]  req_wdata = '0;
    logic [NUM_REQ-1:0]     done;
    logic [DW-1:0]          rdata;
    logic                   busy;
    logic [NUM_REGS-1:0]    reg_enable;
    logic                   reg_readwrite;
    logic [DW-1:0]          reg_in;
    logic [NUM_REGS*DW-1:0] reg_out;

    logic [DW-1:0] bank [NUM_REGS] = '{default: '0};
    logic [EW-1:0] exp_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    int            remaining [NUM_REQ];

    localparam logic [DW-1:0] D1   = 256'h1111;
    localparam logic [DW-1:0] DA   = 256'h0A;
    localparam logic [DW-1:0] DB   = 256'h1B;
    localparam logic [DW-1:0] DC   = 256'h2C;
    localparam logic [DW-1:0] D77  = 256'h77;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    matrix_reg_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .NUM_REGS (NUM_REGS),
        .AW       (AW),
        .DW       (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_rw        (req_rw),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .done          (done),
        .rdata         (rdata),
        .busy          (busy),
        .reg_enable    (reg_enable),
        .reg_readwrite (reg_readwrite),
        .reg_in        (reg_in),
        .reg_out       (reg_out)
    );

    // Clock and bank model
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_enable[i] && !reg_readwrite) bank[i] <= reg_in;
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_out[i*DW +: DW] = bank[i];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [EW-1:0]      e;
        logic [NUM_REQ-1:0] exp_done;
        vectors++;
        if (!$onehot0(reg_enable) || (reg_enable != '0 && !busy)) begin
            miscompares++;
            $display("FAIL enable_shape: got reg_enable=%b busy=%b required one-hot-or-zero, only while busy",
                     reg_enable, busy);
        end
        if (done != '0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: got done=%b required no pulse", done);
            end else begin
                e = exp_q.pop_front();
                exp_done = NUM_REQ'(1) << e[EW-1 -: 3];
                if (done !== exp_done) begin
                    miscompares++;
                    $display("FAIL done_grant: got %b required %b", done, exp_done);
                end
                if (e[DW]) begin
                    vectors++;
                    if (rdata !== e[DW-1:0]) begin
                        miscompares++;
                        $display("FAIL rdata: got %h required %h", rdata, e[DW-1:0]);
                    end
                end
            end
        end
    end

    // Driver tasks
    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_rw[i]            = rw;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic push(input logic [2:0] idx, input logic chk, input logic [DW-1:0] d);
        exp_q.push_back({idx, chk, d});
    endtask

    // Requester behaviour: drop req once its allotted number of done pulses arrives.
    task automatic run_until_idle(input int max_cycles);
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (done[i] && req[i]) begin
                    remaining[i]--;
                    if (remaining[i] <= 0) req[i] = 1'b0;
                end
            end
            n++;
            if (req == '0 && !busy) break;
            if (n >= max_cycles) begin
                vectors++;
                miscompares++;
                $display("FAIL run_timeout: got req=%b busy=%b after %0d cycles required idle", req, busy, n);
                req = '0;
                break;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_done", DW'(done), '0);
        check("reset_rdata", rdata, '0);
        check("reset_busy", DW'(busy), '0);
        check("reset_enable", DW'(reg_enable), '0);
        check("reset_readwrite", DW'(reg_readwrite), 256'd1);
        check("reset_reg_in", reg_in, '0);
        reset = 1'b0;

        // Single write then read on requester 0
        set_op(0, RW_WRITE, 3'd2, D1);
        push(3'd0, 1'b1, '0);
        req = 3'b001;
        remaining[0] = 1;
        @(posedge clk); #1;
        check("issue_enable", DW'(reg_enable), 256'b00000100);
        check("issue_readwrite", DW'(reg_readwrite), '0);
        check("issue_busy", DW'(busy), 256'd1);
        check("issue_reg_in", reg_in, D1);
        @(posedge clk); #1;
        check("latency_done", DW'(done), 256'b001);
        run_until_idle(20);

        set_op(0, RW_READ, 3'd2, '0);
        push(3'd0, 1'b1, D1);
        req = 3'b001;
        remaining[0] = 1;
        run_until_idle(20);

        // All three from reset, held for two rounds: 0,1,2,0,1,2
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        set_op(0, RW_WRITE, 3'd0, DA);
        set_op(1, RW_WRITE, 3'd1, DB);
        set_op(2, RW_WRITE, 3'd3, DC);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < NUM_REQ; k++) push(3'(k), 1'b1, '0);
        end
        for (int i = 0; i < NUM_REQ; i++) remaining[i] = 2;
        req = 3'b111;
        run_until_idle(40);

        // Rotation: req1 alone leaves ptr at 2, then req0 beats req1
        set_op(1, RW_READ, 3'd3, '0);
        push(3'd1, 1'b1, DC);
        req = 3'b010;
        remaining[1] = 1;
        run_until_idle(20);
        set_op(0, RW_READ, 3'd0, '0);
        set_op(1, RW_READ, 3'd1, '0);
        push(3'd0, 1'b1, DA);
        push(3'd1, 1'b1, DB);
        remaining[0] = 1;
        remaining[1] = 1;
        req = 3'b011;
        run_until_idle(20);

        // Read-after-write ordering on reg 5; write leaves rdata unchanged
        set_op(0, RW_WRITE, 3'd5, ONES);
        set_op(1, RW_READ, 3'd5, '0);
        push(3'd0, 1'b1, DB);
        push(3'd1, 1'b1, ONES);
        remaining[0] = 1;
        remaining[1] = 1;
        req = 3'b011;
        run_until_idle(20);

        // Reset during ISSUE abandons the access and clears the pointer
        set_op(2, RW_WRITE, 3'd6, D77);
        req = 3'b100;
        remaining[2] = 1;
        @(posedge clk); #1;
        check("abort_issue_enable", DW'(reg_enable), 256'b01000000);
        reset = 1'b1;
        req = '0;
        @(posedge clk); #1;
        check("abort_enable", DW'(reg_enable), '0);
        check("abort_busy", DW'(busy), '0);
        check("abort_done", DW'(done), '0);
        check("abort_readwrite", DW'(reg_readwrite), 256'd1);
        check("abort_rdata", rdata, '0);
        reset = 1'b0;
        set_op(0, RW_READ, 3'd5, '0);
        set_op(2, RW_READ, 3'd2, '0);
        push(3'd0, 1'b1, ONES);
        push(3'd2, 1'b1, D1);
        remaining[0] = 1;
        remaining[2] = 1;
        req = 3'b101;
        run_until_idle(20);

        // Early drop during ISSUE still completes exactly once
        set_op(2, RW_READ, 3'd1, '0);
        push(3'd2, 1'b1, DB);
        req = 3'b100;
        @(posedge clk); #1;
        req = '0;
        run_until_idle(20);
        repeat (6) @(posedge clk);
        #1;
        check("early_drop_idle", DW'(busy), '0);

        check("queue_drained", DW'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
